// File: rtl/rpsc_interlock_card.sv
// rpsc_interlock_card: alarm aggregation with sticky latches, first-fault capture and a supply-enable sequencer with settle timer
module rpsc_interlock_card #(
  parameter int N_ALARM       = 8,
  parameter int SETTLE_CYCLES = 1562500,
  parameter int TIMER_W       = 21,
  parameter int IDX_W         = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_ALARM-1:0] alarm_in,
  input  logic [N_ALARM-1:0] alarm_mask,
  input  logic               perm_in,
  input  logic               enable_req,
  input  logic               aux_in,
  input  logic               clear_req,
  output logic               clear_ack,
  output logic               not_alarm,
  output logic               ground_hold_ok,
  output logic               not_on_perm,
  output logic               supply_ok_n,
  output logic               aux_ok_n,
  output logic [N_ALARM-1:0] alarm_latched,
  output logic               first_fault_valid,
  output logic [IDX_W-1:0]   first_fault_idx,
  output logic [7:0]         trip_count,
  output logic [1:0]         state
);
  typedef enum logic [1:0] {IDLE = 2'd0, SETTLE = 2'd1, ON = 2'd2, TRIPPED = 2'd3} state_t;
  localparam int SW = N_ALARM + 4;
  localparam logic [TIMER_W-1:0] LAST = TIMER_W'(SETTLE_CYCLES - 1);
  logic [SW-1:0] sync1_q, sync2_q;
  logic [1:0] rst_sync_q;
  logic [N_ALARM-1:0] act, lat_q, lat_d;
  logic perm, en, aux, clr, run, trip, accept;
  logic [IDX_W-1:0] first, ffi_q, ffi_d;
  logic [TIMER_W-1:0] cnt_q, cnt_d;
  logic [7:0] tc_q, tc_d;
  logic ffv_q, ffv_d, ack_q, na_q, na_d, gh_q, gh_d, sup_q, sup_d, auxn_q, auxn_d;
  state_t st_q, st_d;
  assign {perm, en, aux, clr} = sync2_q[3:0];
  assign act    = sync2_q[SW-1:4] & ~alarm_mask;
  assign run    = rst_sync_q[1];
  assign trip   = (st_q != TRIPPED) && (act != '0);
  assign accept = (st_q == TRIPPED) && clr && (act == '0);
  // Synchronisers run freely; the FSM waits for the two-flop reset release
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      rst_sync_q <= '0;
    end else begin
      sync1_q    <= {alarm_in, perm_in, enable_req, aux_in, clear_req};
      sync2_q    <= sync1_q;
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end
  always_comb begin
    first = '0;
    for (int i = N_ALARM - 1; i >= 0; i--) if (act[i]) first = IDX_W'(i);
    st_d  = st_q;
    cnt_d = cnt_q;
    if (trip) begin
      st_d  = TRIPPED;
      cnt_d = '0;
    end else if (accept) begin
      st_d = IDLE;
    end else if (st_q == IDLE && en && perm) begin
      st_d  = SETTLE;
      cnt_d = '0;
    end else if ((st_q == SETTLE || st_q == ON) && !(en && perm)) begin
      st_d  = IDLE;
      cnt_d = '0;
    end else if (st_q == SETTLE) begin
      st_d  = (cnt_q == LAST) ? ON : SETTLE;
      cnt_d = (cnt_q == LAST) ? cnt_q : cnt_q + 1'b1;
    end
    lat_d  = accept ? '0 : (lat_q | act);
    ffv_d  = trip | (ffv_q & ~accept);
    ffi_d  = trip ? first : (accept ? '0 : ffi_q);
    tc_d   = tc_q + {7'd0, trip && (tc_q != 8'hFF)};
    na_d   = st_d != TRIPPED;
    gh_d   = na_d & perm;
    sup_d  = st_d != ON;
    auxn_d = !((st_d == ON) && aux);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q   <= IDLE;
      cnt_q  <= '0;
      lat_q  <= '0;
      ffv_q  <= 1'b0;
      ffi_q  <= '0;
      tc_q   <= '0;
      ack_q  <= 1'b0;
      na_q   <= 1'b1;
      gh_q   <= 1'b0;
      sup_q  <= 1'b1;
      auxn_q <= 1'b1;
    end else if (run) begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      lat_q  <= lat_d;
      ffv_q  <= ffv_d;
      ffi_q  <= ffi_d;
      tc_q   <= tc_d;
      ack_q  <= accept;
      na_q   <= na_d;
      gh_q   <= gh_d;
      sup_q  <= sup_d;
      auxn_q <= auxn_d;
    end
  end
  assign clear_ack         = ack_q;
  assign not_alarm         = na_q;
  assign ground_hold_ok    = gh_q;
  assign not_on_perm       = ~gh_q;
  assign supply_ok_n       = sup_q;
  assign aux_ok_n          = auxn_q;
  assign alarm_latched     = lat_q;
  assign first_fault_valid = ffv_q;
  assign first_fault_idx   = ffi_q;
  assign trip_count        = tc_q;
  assign state             = st_q;
endmodule

// File: tb/tb_rpsc_interlock_card.sv
// tb_rpsc_interlock_card: directed vector table, corner sequences and randomized run against a behavioural model
module tb_rpsc_interlock_card;
  localparam int SC = 8;
  logic clk = 1'b0, reset = 1'b1;
  logic [7:0] alarm_in = '0, alarm_mask = '0;
  logic perm_in = 1'b0, enable_req = 1'b0, aux_in = 1'b0, clear_req = 1'b0;
  logic clear_ack, not_alarm, ground_hold_ok, not_on_perm, supply_ok_n, aux_ok_n;
  logic [7:0] alarm_latched, trip_count;
  logic first_fault_valid;
  logic [2:0] first_fault_idx;
  logic [1:0] state;
  int errs = 0, checks = 0;
  bit mon_en = 1'b0;

  rpsc_interlock_card #(.N_ALARM(8), .SETTLE_CYCLES(SC), .TIMER_W(4), .IDX_W(3)) dut (
    .clk(clk), .reset(reset), .alarm_in(alarm_in), .alarm_mask(alarm_mask),
    .perm_in(perm_in), .enable_req(enable_req), .aux_in(aux_in), .clear_req(clear_req),
    .clear_ack(clear_ack), .not_alarm(not_alarm), .ground_hold_ok(ground_hold_ok),
    .not_on_perm(not_on_perm), .supply_ok_n(supply_ok_n), .aux_ok_n(aux_ok_n),
    .alarm_latched(alarm_latched), .first_fault_valid(first_fault_valid),
    .first_fault_idx(first_fault_idx), .trip_count(trip_count), .state(state));

  always #5 clk = ~clk;

  function automatic logic [27:0] pk(logic [1:0] st, bit ack, bit na, bit gh, bit sup, bit auxn,
                                     logic [7:0] lat, bit ffv, logic [2:0] ffi, logic [7:0] tc);
    return {st, ack, na, gh, !gh, sup, auxn, lat, ffv, ffi, tc};
  endfunction

  function automatic logic [27:0] outs();
    return {state, clear_ack, not_alarm, ground_hold_ok, not_on_perm, supply_ok_n, aux_ok_n,
            alarm_latched, first_fault_valid, first_fault_idx, trip_count};
  endfunction

  localparam logic [27:0] RST = 28'({2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 3'd0, 8'd0});

  task automatic check(string name, logic [27:0] exp);
    checks++;
    if (outs() !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, outs(), exp, $time);
    end
  endtask

  // Behavioural reference: inputs seen two edges late, mode values are the state codes
  int m_mode = 0, m_time = 0, m_trips = 0, m_ffi = 0, rcnt = 0;
  logic [7:0] m_lat = '0;
  bit m_ffv = 0, m_ack = 0, m_na = 1, m_gh = 0, m_sup = 1, m_auxn = 1;
  logic [11:0] d1 = '0, d2 = '0;

  task automatic m_step(logic [7:0] a, logic [7:0] mk, bit pm, bit en, bit ax, bit cl);
    logic [7:0] act;
    act = a & ~mk;
    m_ack = 0;
    m_lat = m_lat | act;
    if (m_mode != 3 && act != 0) begin
      m_mode = 3;
      m_time = 0;
      m_trips = (m_trips < 255) ? m_trips + 1 : 255;
      m_ffv = 1;
      m_ffi = 0;
      while (!act[m_ffi]) m_ffi++;
    end else if (m_mode == 3) begin
      if (cl && act == 0) begin
        m_mode = 0; m_ack = 1; m_lat = '0; m_ffv = 0; m_ffi = 0;
      end
    end else if (m_mode == 0) begin
      if (en && pm) begin m_mode = 1; m_time = 0; end
    end else if (!(en && pm)) begin
      m_mode = 0;
    end else if (m_mode == 1) begin
      m_time++;
      if (m_time == SC) m_mode = 2;
    end
    m_na = m_mode != 3;
    m_gh = m_na && pm;
    m_sup = m_mode != 2;
    m_auxn = !(m_mode == 2 && ax);
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_mode = 0; m_time = 0; m_trips = 0; m_ffi = 0; rcnt = 0; m_lat = '0;
      m_ffv = 0; m_ack = 0; m_na = 1; m_gh = 0; m_sup = 1; m_auxn = 1; d1 = '0; d2 = '0;
    end else begin
      if (rcnt >= 2) m_step(d2[11:4], alarm_mask, d2[3], d2[2], d2[1], d2[0]);
      d2 = d1;
      d1 = {alarm_in, perm_in, enable_req, aux_in, clear_req};
      if (rcnt < 2) rcnt++;
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (outs() !== pk(2'(m_mode), m_ack, m_na, m_gh, m_sup, m_auxn, m_lat, m_ffv, 3'(m_ffi), 8'(m_trips))) begin
        errs++;
        $display("FAIL model: got %h expected %h at %0t", outs(),
                 pk(2'(m_mode), m_ack, m_na, m_gh, m_sup, m_auxn, m_lat, m_ffv, 3'(m_ffi), 8'(m_trips)), $time);
      end
    end
  end

  task automatic wait_state(logic [1:0] s, int limit);
    int n = 0;
    while (state !== s && n < limit) begin @(negedge clk); n++; end
    checks++;
    if (state !== s) begin
      errs++;
      $display("FAIL wait_state: got %0d expected %0d", state, s);
    end
  endtask

  typedef struct {
    logic [7:0] al, mk; bit pm, en, ax, cl; int hold;
    logic [1:0] st; bit ack, na, gh, sup, auxn; logic [7:0] lat; bit ffv; logic [2:0] ffi; logic [7:0] tc;
  } vec_t;
  vec_t tbl[28];

  initial begin
    tbl[0]  = '{8'h00, 8'h00, 0, 0, 0, 0, 2, 2'd0, 0, 1, 0, 1, 1, 8'h00, 0, 3'd0, 8'd0};
    tbl[1]  = '{8'h00, 8'h00, 1, 0, 0, 0, 3, 2'd0, 0, 1, 1, 1, 1, 8'h00, 0, 3'd0, 8'd0};
    tbl[2]  = '{8'h00, 8'h00, 1, 1, 0, 0, 2, 2'd0, 0, 1, 1, 1, 1, 8'h00, 0, 3'd0, 8'd0};
    tbl[3]  = '{8'h00, 8'h00, 1, 1, 0, 0, 1, 2'd1, 0, 1, 1, 1, 1, 8'h00, 0, 3'd0, 8'd0};
    tbl[4]  = '{8'h00, 8'h00, 1, 1, 0, 0, 7, 2'd1, 0, 1, 1, 1, 1, 8'h00, 0, 3'd0, 8'd0};
    tbl[5]  = '{8'h00, 8'h00, 1, 1, 0, 0, 1, 2'd2, 0, 1, 1, 0, 1, 8'h00, 0, 3'd0, 8'd0};
    tbl[6]  = '{8'h00, 8'h00, 1, 1, 1, 0, 2, 2'd2, 0, 1, 1, 0, 1, 8'h00, 0, 3'd0, 8'd0};
    tbl[7]  = '{8'h00, 8'h00, 1, 1, 1, 0, 1, 2'd2, 0, 1, 1, 0, 0, 8'h00, 0, 3'd0, 8'd0};
    tbl[8]  = '{8'h00, 8'h00, 1, 0, 1, 0, 3, 2'd0, 0, 1, 1, 1, 1, 8'h00, 0, 3'd0, 8'd0};
    tbl[9]  = '{8'h00, 8'h00, 1, 1, 1, 0, 3, 2'd1, 0, 1, 1, 1, 1, 8'h00, 0, 3'd0, 8'd0};
    tbl[10] = '{8'h00, 8'h00, 1, 1, 1, 0, 2, 2'd1, 0, 1, 1, 1, 1, 8'h00, 0, 3'd0, 8'd0};
    tbl[11] = '{8'h00, 8'h00, 1, 0, 1, 0, 3, 2'd0, 0, 1, 1, 1, 1, 8'h00, 0, 3'd0, 8'd0};
    tbl[12] = '{8'h00, 8'h00, 1, 1, 1, 0, 3, 2'd1, 0, 1, 1, 1, 1, 8'h00, 0, 3'd0, 8'd0};
    tbl[13] = '{8'h00, 8'h00, 1, 1, 1, 0, 7, 2'd1, 0, 1, 1, 1, 1, 8'h00, 0, 3'd0, 8'd0};
    tbl[14] = '{8'h00, 8'h00, 1, 1, 1, 0, 1, 2'd2, 0, 1, 1, 0, 0, 8'h00, 0, 3'd0, 8'd0};
    tbl[15] = '{8'h24, 8'h00, 1, 1, 1, 0, 2, 2'd2, 0, 1, 1, 0, 0, 8'h00, 0, 3'd0, 8'd0};
    tbl[16] = '{8'h24, 8'h00, 1, 1, 1, 0, 1, 2'd3, 0, 0, 0, 1, 1, 8'h24, 1, 3'd2, 8'd1};
    tbl[17] = '{8'h20, 8'h00, 1, 0, 1, 1, 5, 2'd3, 0, 0, 0, 1, 1, 8'h24, 1, 3'd2, 8'd1};
    tbl[18] = '{8'h00, 8'h00, 1, 0, 1, 1, 2, 2'd3, 0, 0, 0, 1, 1, 8'h24, 1, 3'd2, 8'd1};
    tbl[19] = '{8'h00, 8'h00, 1, 0, 1, 1, 1, 2'd0, 1, 1, 1, 1, 1, 8'h00, 0, 3'd0, 8'd1};
    tbl[20] = '{8'h00, 8'h00, 1, 0, 1, 1, 1, 2'd0, 0, 1, 1, 1, 1, 8'h00, 0, 3'd0, 8'd1};
    tbl[21] = '{8'h08, 8'h08, 1, 0, 1, 0, 4, 2'd0, 0, 1, 1, 1, 1, 8'h00, 0, 3'd0, 8'd1};
    tbl[22] = '{8'h00, 8'h08, 1, 0, 1, 0, 3, 2'd0, 0, 1, 1, 1, 1, 8'h00, 0, 3'd0, 8'd1};
    tbl[23] = '{8'h01, 8'h00, 1, 0, 1, 0, 1, 2'd0, 0, 1, 1, 1, 1, 8'h00, 0, 3'd0, 8'd1};
    tbl[24] = '{8'h00, 8'h00, 1, 0, 1, 0, 2, 2'd3, 0, 0, 0, 1, 1, 8'h01, 1, 3'd0, 8'd2};
    tbl[25] = '{8'h00, 8'h01, 1, 0, 1, 0, 3, 2'd3, 0, 0, 0, 1, 1, 8'h01, 1, 3'd0, 8'd2};
    tbl[26] = '{8'h00, 8'h01, 1, 0, 1, 1, 3, 2'd0, 1, 1, 1, 1, 1, 8'h00, 0, 3'd0, 8'd2};
    tbl[27] = '{8'h00, 8'h00, 1, 0, 1, 0, 2, 2'd0, 0, 1, 1, 1, 1, 8'h00, 0, 3'd0, 8'd2};

    #1 reset = 1'b0;
    mon_en = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_values", RST);
    reset = 1'b1;
    for (int i = 0; i < 28; i++) begin
      alarm_in = tbl[i].al; alarm_mask = tbl[i].mk; perm_in = tbl[i].pm;
      enable_req = tbl[i].en; aux_in = tbl[i].ax; clear_req = tbl[i].cl;
      repeat (tbl[i].hold) @(negedge clk);
      check($sformatf("vec%0d", i), pk(tbl[i].st, tbl[i].ack, tbl[i].na, tbl[i].gh, tbl[i].sup,
                                      tbl[i].auxn, tbl[i].lat, tbl[i].ffv, tbl[i].ffi, tbl[i].tc));
    end

    enable_req = 1'b1;
    wait_state(2'd1, 10);
    @(posedge clk); #2 reset = 1'b0;
    #1 check("reset_in_settle", RST);
    @(negedge clk) reset = 1'b1;
    enable_req = 1'b0;
    alarm_in = 8'h01;
    wait_state(2'd3, 10);
    @(posedge clk); #2 reset = 1'b0;
    #1 check("reset_in_tripped", RST);
    alarm_in = 8'h00;
    @(negedge clk) reset = 1'b1;
    repeat (3) @(negedge clk);

    for (int k = 0; k < 300; k++) begin
      @(negedge clk) alarm_in = 8'h01;
      repeat (2) @(negedge clk);
      alarm_in = 8'h00; clear_req = 1'b1;
      repeat (4) @(negedge clk);
      clear_req = 1'b0;
    end
    repeat (3) @(negedge clk);
    check("trip_saturate", pk(2'd0, 0, 1, 1, 1, 1, 8'h00, 0, 3'd0, 8'd255));

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      alarm_in = ($urandom_range(0, 29) == 0) ? 8'(1 << $urandom_range(0, 7)) :
                 ($urandom_range(0, 59) == 0) ? 8'($urandom) : 8'h00;
      perm_in = $urandom_range(0, 19) != 0;
      enable_req = $urandom_range(0, 14) != 0;
      aux_in = $urandom_range(0, 3) != 0;
      clear_req = $urandom_range(0, 5) == 0;
      if ($urandom_range(0, 99) == 0) alarm_mask = 8'($urandom) & 8'($urandom);
      if ($urandom_range(0, 499) == 0) begin
        #2 reset = 1'b0;
        #2 reset = 1'b1;
      end
    end
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/rpsc_interlock_card.md
Name: rpsc_interlock_card

Overview:
- Parametrised successor to the fixed-wiring RPSC interlock cards.
- Aggregates N synchronised alarm inputs with a per-channel mask and sticky latches, and captures the first fault.
- A supply-enable state machine with a programmable settle timer gates the supply-OK and auxiliary-OK outputs.
- Trips require an explicit clear handshake to recover. One instance per supply channel on a card.

Parameters:
N_ALARM, 8, number of alarm inputs (1..32)
SETTLE_CYCLES, 1562500, clk cycles from SETTLE entry to ON (>=1; 2 s at 1.28 us)
TIMER_W, 21, settle counter width; must satisfy 2^TIMER_W > SETTLE_CYCLES
IDX_W, 3, first-fault index width; must satisfy 2^IDX_W >= N_ALARM

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
alarm_in  in  N_ALARM  raw alarm inputs, active-high, asynchronous
alarm_mask  in  N_ALARM  1 = channel ignored; quasi-static, not synchronised
perm_in  in  1  supply permissive (e.g. anode PS healthy), active-high, asynchronous
enable_req  in  1  supply enable request, level, asynchronous
aux_in  in  1  auxiliary healthy input (e.g. U low OK), asynchronous
clear_req  in  1  trip clear request, level or pulse
clear_ack  out  1  one-cycle pulse when a clear is accepted
not_alarm  out  1  1 when state != TRIPPED
ground_hold_ok  out  1  not_alarm & synced perm_in
not_on_perm  out  1  ~ground_hold_ok
supply_ok_n  out  1  0 only in ON
aux_ok_n  out  1  ~(ON & synced aux_in)
alarm_latched  out  N_ALARM  sticky per-channel alarm flags
first_fault_valid  out  1  first_fault_idx holds a captured value
first_fault_idx  out  IDX_W  index of the first channel that tripped
trip_count  out  8  number of trips, saturating at 255
state  out  2  IDLE=0, SETTLE=1, ON=2, TRIPPED=3

Behaviour:
- Reset (reset=0, asynchronous):
  - All synchronisers, latches and counters are cleared; state = IDLE.
  - Outputs: clear_ack=0, not_alarm=1, ground_hold_ok=0, not_on_perm=1, supply_ok_n=1, aux_ok_n=1, alarm_latched=0, first_fault_valid=0, first_fault_idx=0, trip_count=0.
  - Reset deassertion is synchronised internally: two-flop release before the FSM advances.
- Synchronisation:
  - alarm_in, perm_in, enable_req, aux_in and clear_req each pass through a 2-flop synchroniser.
  - "Synced" below means the second-stage value.
- Active alarm: act = synced alarm & ~alarm_mask.
- Latency: an input change sampled at edge k appears in synced values after edge k+1. State, latch and output updates occur at edge k+2. All outputs are registered.
- Latches:
  - alarm_latched[i] is set on any edge where act[i]=1.
  - It is cleared only by an accepted clear.
  - Masked channels never set their latch. Setting a mask bit does not clear an existing latch.
- First fault:
  - Captured on the edge that transitions the FSM into TRIPPED.
  - The lowest active index wins on simultaneous alarms.
  - Held until an accepted clear, which zeroes the index and valid flag.
- FSM, priorities top-down each cycle:
  - Any state except TRIPPED, with |act -> TRIPPED. trip_count increments (saturating) and the settle counter is cleared.
  - TRIPPED:
    - Synced clear_req=1 and act==0 -> IDLE, and clear_ack=1 for exactly one cycle.
    - Clear with act!=0 is ignored; no ack is issued.
    - A held clear_req produces one ack per entry into TRIPPED.
  - IDLE: enable_req & ground_hold_ok -> SETTLE, counter=0.
  - SETTLE:
    - Loss of enable_req or perm -> IDLE and counter cleared. This is not a trip.
    - Otherwise the counter increments. At count SETTLE_CYCLES-1 -> ON, so supply_ok_n falls exactly SETTLE_CYCLES cycles after state first reads SETTLE.
  - ON: loss of enable_req or perm -> IDLE; supply_ok_n=1 on the next cycle.
- clear_req outside TRIPPED has no effect and produces no ack.
- Alarm and clear on the same edge in any state: the trip wins.

Test Plan:
- Bench uses SETTLE_CYCLES=8.
- Reset held 0, then released; all inputs 0 -> state=IDLE, not_alarm=1, ground_hold_ok=0, supply_ok_n=1, trip_count=0.
- perm_in=1, enable_req=1 -> state=SETTLE; supply_ok_n=0 exactly 8 cycles later. aux_in=1 -> aux_ok_n=0 after 2 further cycles. Drop enable_req at settle count 5 -> IDLE, counter restarts from 0 on re-request.
- In ON, alarm_in=8'b0010_0100 -> after edge k+2: state=TRIPPED, first_fault_idx=2, alarm_latched=8'h24, supply_ok_n=1, not_alarm=0, trip_count=1.
- clear_req=1 while alarm_in[5] is still 1 -> no clear_ack, stays TRIPPED. Alarms drop -> one clear_ack pulse, latches=0, first_fault_valid=0, state=IDLE.
- alarm_mask[3]=1, pulse alarm_in[3] -> no trip, alarm_latched[3]=0. Unmasked 1-cycle alarm_in[0] glitch spanning a sample edge -> trip and latch[0]=1.
- Assert reset=0 mid-SETTLE and in TRIPPED -> immediate return to the reset values listed above. Force 300 trips -> trip_count=255.
